// File: rtl/spi_mpu_responder.sv
// SPI mode-0 responder emulating a small MPU-style register set (WHO_AM_I, temperature, power management).
// All SPI pins are resynchronized into i_Clk; the state table below covers the transaction FSM.
//   state | meaning
//   IDLE  | no transaction, waiting for a CS falling edge
//   CMD   | shifting in the command byte (rw + 7-bit address)
//   DATA  | burst of data bytes, address auto-increments per byte
module spi_mpu_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter logic [7:0] PWR_RST_VAL  = 8'h40
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_SPI_Clk,
  input  logic        i_SPI_MOSI,
  input  logic        i_cs_n,
  output logic        o_SPI_MISO,
  input  logic [15:0] i_temp,
  output logic [7:0]  o_pwr_mgmt,
  output logic        o_busy,
  output logic        o_txn_done
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cs_sync, r_sclk_sync, r_mosi_sync;
  logic        r_cs_d, r_sclk_d;
  logic [1:0]  r_sync_vld;
  logic        r_armed;
  logic [7:0]  r_rx_shift, r_tx_shift;
  logic [2:0]  r_bit_cnt;
  logic        r_rw;
  logic [6:0]  r_addr;
  logic [15:0] r_snap;
  logic [7:0]  r_pwr;
  logic        r_load_pend;
  logic        r_miso, r_busy, r_txn_done;

  logic       w_cs, w_sclk, w_mosi;
  logic       w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic       w_in_txn, w_byte_done;
  logic [7:0] w_rx_byte, w_rd_data;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_cs_sync   <= 2'b11;
      r_sclk_sync <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
      r_sync_vld  <= 2'b00;
      r_armed     <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], i_cs_n};
      r_sclk_sync <= {r_sclk_sync[0], i_SPI_Clk};
      r_mosi_sync <= {r_mosi_sync[0], i_SPI_MOSI};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
      r_sync_vld  <= {r_sync_vld[0], 1'b1};
      // Only trust a CS falling edge once CS has been seen high after reset,
      // so a transaction interrupted by reset is ignored to its end.
      if (r_sync_vld[1] && w_cs)
        r_armed <= 1'b1;
    end
  end

  assign w_cs        = r_cs_sync[1];
  assign w_sclk      = r_sclk_sync[1];
  assign w_mosi      = r_mosi_sync[1];
  assign w_in_txn    = (r_state != IDLE);
  assign w_cs_fall   = r_armed & r_cs_d & ~w_cs;
  assign w_cs_rise   = ~r_cs_d & w_cs;
  assign w_sclk_rise = w_in_txn & ~r_sclk_d & w_sclk;
  assign w_sclk_fall = w_in_txn & r_sclk_d & ~w_sclk;
  assign w_byte_done = w_sclk_rise & (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_shift[6:0], w_mosi};

  always_comb begin
    w_rd_data = 8'h00;
    case (r_addr)
      7'h41:   w_rd_data = r_snap[15:8];
      7'h42:   w_rd_data = r_snap[7:0];
      7'h6B:   w_rd_data = r_pwr;
      7'h75:   w_rd_data = WHO_AM_I_VAL;
      default: w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_cs_fall) w_state_nxt = CMD;
        CMD:     if (w_byte_done) w_state_nxt = DATA;
        DATA:    w_state_nxt = DATA;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx_shift  <= 8'h00;
      r_tx_shift  <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_rw        <= 1'b0;
      r_addr      <= 7'd0;
      r_snap      <= 16'h0000;
      r_pwr       <= PWR_RST_VAL;
      r_load_pend <= 1'b0;
      r_miso      <= 1'b0;
      r_busy      <= 1'b0;
      r_txn_done  <= 1'b0;
    end else begin
      r_txn_done <= w_cs_rise & w_in_txn;
      r_busy     <= r_armed & ~w_cs;
      if (w_cs_rise) begin
        r_bit_cnt   <= 3'd0;
        r_load_pend <= 1'b0;
        r_tx_shift  <= 8'h00;
        r_miso      <= 1'b0;
      end else if (w_cs_fall && r_state == IDLE) begin
        r_snap      <= i_temp;
        r_bit_cnt   <= 3'd0;
        r_rx_shift  <= 8'h00;
        r_tx_shift  <= 8'h00;
        r_load_pend <= 1'b0;
        r_miso      <= 1'b0;
      end else if (w_in_txn) begin
        if (w_sclk_rise) begin
          r_rx_shift <= w_rx_byte;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            if (r_state == CMD) begin
              r_rw        <= w_rx_byte[7];
              r_addr      <= w_rx_byte[6:0];
              r_load_pend <= w_rx_byte[7];
            end else begin
              if (!r_rw && r_addr == 7'h6B)
                r_pwr <= w_rx_byte;
              r_addr      <= r_addr + 7'd1;
              r_load_pend <= r_rw;
            end
          end
        end
        // Next read byte is fetched after the address update so bursts see addr+1.
        if (w_sclk_fall && r_state == DATA && r_rw) begin
          if (r_load_pend) begin
            r_tx_shift  <= w_rd_data;
            r_miso      <= w_rd_data[7];
            r_load_pend <= 1'b0;
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            r_miso     <= r_tx_shift[6];
          end
        end
      end
    end
  end

  assign o_SPI_MISO = r_miso & ~w_cs;
  assign o_pwr_mgmt = r_pwr;
  assign o_busy     = r_busy;
  assign o_txn_done = r_txn_done;

endmodule

// File: tb/tb_spi_mpu_responder.sv
// Bench for spi_mpu_responder: table of SPI transactions with a read-byte scoreboard,
// followed by hand sequences for abort, zero-byte and reset-mid-read cases.
module tb_spi_mpu_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic [15:0] temp = 16'h0000;
  logic        miso;
  logic [7:0]  pwr;
  logic        busy;
  logic        done;

  spi_mpu_responder dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_SPI_Clk  (sclk),
    .i_SPI_MOSI (mosi),
    .i_cs_n     (cs_n),
    .o_SPI_MISO (miso),
    .i_temp     (temp),
    .o_pwr_mgmt (pwr),
    .o_busy     (busy),
    .o_txn_done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    int          nb;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] temp;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  epwr;
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  vec_t       vt[13];

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Mode 0 master: MOSI set while SCLK low, MISO sampled at the rising edge.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      mosi = tx[7-b];
      #50 sclk = 1'b1;
      rx = {rx[6:0], miso};
      #50 sclk = 1'b0;
    end
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    logic [7:0] rx;
    logic [7:0] data;
    logic [7:0] exp;
    int         d0;
    @(negedge clk);
    temp = v.temp;
    d0 = done_cnt;
    cs_n = 1'b0;
    #50;
    temp = 16'h0000;
    spi_byte(v.cmd, 8, rx);
    chk({nm, "_busy"}, 16'(busy), 16'h1);
    for (int k = 0; k < v.nb; k++) begin
      data = v.cmd[7] ? 8'h00 : (k == 0 ? v.d0 : v.d1);
      if (v.cmd[7]) exp_q.push_back(k == 0 ? v.e0 : v.e1);
      spi_byte(data, 8, rx);
      if (v.cmd[7]) begin
        if (exp_q.size() == 0) begin
          chk({nm, "_sb_empty"}, 16'(exp_q.size()), 16'h1);
        end else begin
          exp = exp_q.pop_front();
          chk({nm, "_rd"}, 16'(rx), 16'(exp));
        end
      end
    end
    cs_n = 1'b1;
    #100;
    chk({nm, "_pwr"}, 16'(pwr), 16'(v.epwr));
    chk({nm, "_done"}, 16'(done_cnt - d0), 16'h1);
    chk({nm, "_idle_busy"}, 16'(busy), 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int         d0;
    vec_t       v;

    vt[0]  = '{8'hF5, 1, 8'h00, 8'h00, 16'h1234, 8'h68, 8'h00, 8'h40};
    vt[1]  = '{8'hC1, 2, 8'h00, 8'h00, 16'hFC18, 8'hFC, 8'h18, 8'h40};
    vt[2]  = '{8'hEB, 1, 8'h00, 8'h00, 16'h0000, 8'h40, 8'h00, 8'h40};
    vt[3]  = '{8'h6B, 1, 8'h01, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h01};
    vt[4]  = '{8'hEB, 1, 8'h00, 8'h00, 16'h0000, 8'h01, 8'h00, 8'h01};
    vt[5]  = '{8'h41, 1, 8'h55, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h01};
    vt[6]  = '{8'hC1, 2, 8'h00, 8'h00, 16'h1234, 8'h12, 8'h34, 8'h01};
    vt[7]  = '{8'hFF, 2, 8'h00, 8'h00, 16'hFFFF, 8'h00, 8'h00, 8'h01};
    vt[8]  = '{8'hF4, 2, 8'h00, 8'h00, 16'h0000, 8'h00, 8'h68, 8'h01};
    vt[9]  = '{8'hEA, 2, 8'h00, 8'h00, 16'hA5C3, 8'h00, 8'h01, 8'h01};
    vt[10] = '{8'hC2, 1, 8'h00, 8'h00, 16'h8001, 8'h01, 8'h00, 8'h01};
    vt[11] = '{8'h6B, 2, 8'h3C, 8'h77, 16'h0000, 8'h00, 8'h00, 8'h3C};
    vt[12] = '{8'hEB, 1, 8'h00, 8'h00, 16'h0000, 8'h3C, 8'h00, 8'h3C};

    #12;
    chk("rst_miso", 16'(miso), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_pwr", 16'(pwr), 16'h40);
    #8 rst_n = 1'b1;
    #100;

    for (int i = 0; i < 13; i++)
      run_txn(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a WHO_AM_I data byte (MISO is high at that point).
    @(negedge clk);
    cs_n = 1'b0;
    #50;
    spi_byte(8'hF5, 8, rx);
    spi_byte(8'h00, 2, rx);
    chk("pre_rst_miso", 16'(miso), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_miso", 16'(miso), 16'h0);
    chk("midrst_pwr", 16'(pwr), 16'h40);
    #19 rst_n = 1'b1;
    d0 = done_cnt;
    spi_byte(8'hFF, 6, rx);
    chk("postrst_miso", 16'(rx), 16'h0);
    chk("postrst_busy", 16'(busy), 16'h0);
    cs_n = 1'b1;
    #100;
    chk("postrst_done", 16'(done_cnt - d0), 16'h0);
    chk("postrst_pwr", 16'(pwr), 16'h40);
    run_txn(vt[0], "postrst_who");

    // Abort a write after 4 data bits.
    @(negedge clk);
    d0 = done_cnt;
    cs_n = 1'b0;
    #50;
    spi_byte(8'h6B, 8, rx);
    spi_byte(8'hAA, 4, rx);
    cs_n = 1'b1;
    #100;
    chk("abort_pwr", 16'(pwr), 16'h40);
    chk("abort_done", 16'(done_cnt - d0), 16'h1);
    v = '{8'h6B, 1, 8'h5A, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h5A};
    run_txn(v, "after_abort_wr");
    v = '{8'hEB, 1, 8'h00, 8'h00, 16'h0000, 8'h5A, 8'h00, 8'h5A};
    run_txn(v, "after_abort_rd");

    // Zero-byte transaction.
    @(negedge clk);
    d0 = done_cnt;
    cs_n = 1'b0;
    #100;
    cs_n = 1'b1;
    #100;
    chk("zero_done", 16'(done_cnt - d0), 16'h1);
    chk("zero_pwr", 16'(pwr), 16'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
